fpaddsub_share_arbiter: RTL

- Shares one fixed-latency pipelined FP add/sub unit (align, add, normalize-shift, round) among NREQ requesters.
- Round-robin arbitration on the request side; one operation is issued per cycle at most.
- An internal tag pipeline tracks each in-flight operation and routes the result and flags back to the requester that issued it.
- Sits between the PE-level operand sources and the FP_AddSub datapath.

---
 rtl/fpaddsub_share_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/fpaddsub_share_arbiter.sv
// Round-robin front end that shares one fixed-latency pipelined FP add/sub unit among NREQ
// requesters, tracking each in-flight operation so its result returns to the issuer.
module fpaddsub_share_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LAT   = 5,
  parameter int unsigned TAGW  = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ-1:0]         req_op,
  output logic                    fu_valid,
  output logic [WIDTH-1:0]        fu_a,
  output logic [WIDTH-1:0]        fu_b,
  output logic                    fu_op,
  input  logic [WIDTH-1:0]        fu_result,
  input  logic [4:0]              fu_flags,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]        rsp_data,
  output logic [4:0]              rsp_flags,
  output logic                    busy
);

  logic [TAGW-1:0] rr_ptr;
  logic [TAGW-1:0] win_idx;
  logic            win_found;
  logic            hs;
  logic [TAGW-1:0] fu_tag;
  logic [LAT-1:0]  tag_vld;
  logic [TAGW-1:0] tag_id [LAT];

  // Scan from rr_ptr upward, wrapping modulo NREQ; first valid requester wins.
  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr) + k) % NREQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = TAGW'(idx);
      end
    end
  end

  assign hs        = win_found & ~flush;
  assign req_ready = hs ? (NREQ'(1) << win_idx) : '0;
  assign busy      = fu_valid | (|tag_vld);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      fu_valid <= 1'b0;
      fu_a     <= '0;
      fu_b     <= '0;
      fu_op    <= 1'b0;
      fu_tag   <= '0;
    end else begin
      fu_valid <= hs;
      if (hs) begin
        rr_ptr <= (win_idx == TAGW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        fu_a   <= req_a[32'(win_idx)*WIDTH +: WIDTH];
        fu_b   <= req_b[32'(win_idx)*WIDTH +: WIDTH];
        fu_op  <= req_op[win_idx];
        fu_tag <= win_idx;
      end
    end
  end

  // Stage 0 captures the op the unit is sampling now; stage LAT-1 lines up with fu_result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      for (int unsigned k = 0; k < LAT; k++) tag_id[k] <= '0;
    end else begin
      tag_id[0] <= fu_tag;
      for (int unsigned k = 1; k < LAT; k++) tag_id[k] <= tag_id[k-1];
      if (flush) begin
        tag_vld <= '0;
      end else begin
        tag_vld[0] <= fu_valid;
        for (int unsigned k = 1; k < LAT; k++) tag_vld[k] <= tag_vld[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_flags <= '0;
    end else if (!flush && tag_vld[LAT-1]) begin
      rsp_valid <= NREQ'(1) << tag_id[LAT-1];
      rsp_data  <= fu_result;
      rsp_flags <= fu_flags;
    end else begin
      rsp_valid <= '0;
    end
  end

endmodule
